// File: rtl/lupdate_parser.sv
`default_nettype none
// ============================================================================
// Module  : lupdate_parser
// Purpose : Forwards a 134-bit beat stream through a fixed 3-stage pipeline.
//           Beacon update packets are detected on beat 2 and removed from the
//           stream, and their beat-6 contents are committed to configuration
//           registers when the tail arrives. Orphan beats (no open packet) are
//           discarded.
// Ports   : clk, rst (sync, active-high)
//           in_lu_data_wr / in_lu_data[133:0] / in_lu_data_valid(_wr) : input stream
//           in_local_mac_id[47:0]                                      : local MAC
//           out_lu_data_wr / out_lu_data / out_lu_data_valid(_wr)      : output stream
//           direction, token_bucket_para[31:0], direct_mac_addr[47:0]  : config
//           beacon_update_master : toggles per committed update
//           update_cnt, drop_cnt : committed updates / discarded beats
// Rev     : 1.0  initial release
// ============================================================================
module lupdate_parser #(
  parameter logic [47:0] CNC_MAC     = 48'h010203040506,
  parameter logic [31:0] RST_TB_PARA = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_lu_data_wr,
  input  logic [133:0] in_lu_data,
  input  logic         in_lu_data_valid,
  input  logic         in_lu_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  output logic         out_lu_data_wr,
  output logic [133:0] out_lu_data,
  output logic         out_lu_data_valid,
  output logic         out_lu_data_valid_wr,
  output logic         direction,
  output logic [31:0]  token_bucket_para,
  output logic [47:0]  direct_mac_addr,
  output logic         beacon_update_master,
  output logic [31:0]  update_cnt,
  output logic [31:0]  drop_cnt
);

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  // upd : beat belongs to a packet already known to be an update.
  // pend: beat belongs to the open packet whose beat 2 has not been seen yet,
  //       so its fate is decided later while it is still in flight.
  typedef struct packed {
    logic         wr;
    logic [133:0] data;
    logic         valid;
    logic         valid_wr;
    logic         upd;
    logic         pend;
  } stage_t;

  stage_t      s1, s2, s1_nxt, s2_nxt;
  logic        pkt_open;
  logic        cls_upd;
  logic [3:0]  idx;
  logic [47:0] sh_mac;
  logic        sh_dir;
  logic [31:0] sh_tb;

  logic [1:0]  tag;
  logic        is_head, is_tail, orphan, in_pkt;
  logic [3:0]  cur_idx;
  logic        match, resolve, upd_beat, commit, cap6;
  logic        s2_upd_eff, supp;

  assign tag     = in_lu_data[133:132];
  assign is_head = in_lu_data_wr && (tag == TAG_HEAD);
  assign is_tail = in_lu_data_wr && (tag == TAG_TAIL);
  assign orphan  = in_lu_data_wr && !pkt_open && (tag != TAG_HEAD);
  // a non-head beat that continues the currently open packet
  assign in_pkt  = in_lu_data_wr && pkt_open && (tag != TAG_HEAD);
  assign cur_idx = is_head ? 4'd0 : ((idx == 4'd15) ? 4'd15 : idx + 4'd1);

  assign match = in_pkt && (cur_idx == 4'd2)
              && (in_lu_data[127:80] == in_local_mac_id)
              && (in_lu_data[79:32]  == CNC_MAC)
              && (in_lu_data[31:16]  == 16'h88F7)
              && (in_lu_data[11:8]   == 4'hD);

  // Events that settle the fate of pending beats: the classifying beat, a
  // tail before beat 2, or a new head abandoning the open packet.
  assign resolve  = is_head || (in_pkt && ((cur_idx == 4'd2) || is_tail));
  assign upd_beat = in_pkt && (cls_upd || match);
  assign cap6     = in_pkt && cls_upd && (cur_idx == 4'd6);
  assign commit   = in_pkt && is_tail && cls_upd && (cur_idx >= 4'd6);

  // Beat 0 sits in stage 2 when beat 2 is classified, so the late decision
  // is applied on the stage 2 -> output transfer as well.
  assign s2_upd_eff = s2.upd || (s2.pend && match);
  assign supp       = s2.wr && s2_upd_eff;

  always_comb begin
    s1_nxt          = '0;
    s1_nxt.wr       = in_lu_data_wr && !orphan;
    s1_nxt.data     = orphan ? '0 : in_lu_data;
    s1_nxt.valid    = orphan ? 1'b0 : in_lu_data_valid;
    s1_nxt.valid_wr = orphan ? 1'b0 : in_lu_data_valid_wr;
    s1_nxt.upd      = upd_beat;
    s1_nxt.pend     = is_head || (in_pkt && (cur_idx < 4'd2) && !is_tail);

    s2_nxt          = s1;
    s2_nxt.upd      = s1.upd || (s1.pend && match);
    s2_nxt.pend     = s1.pend && !resolve;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1                   <= '0;
      s2                   <= '0;
      out_lu_data_wr       <= 1'b0;
      out_lu_data          <= '0;
      out_lu_data_valid    <= 1'b0;
      out_lu_data_valid_wr <= 1'b0;
      pkt_open             <= 1'b0;
      cls_upd              <= 1'b0;
      idx                  <= 4'd0;
      sh_mac               <= '0;
      sh_dir               <= 1'b0;
      sh_tb                <= '0;
      direction            <= 1'b0;
      token_bucket_para    <= RST_TB_PARA;
      direct_mac_addr      <= '0;
      beacon_update_master <= 1'b0;
      update_cnt           <= '0;
      drop_cnt             <= '0;
    end else begin
      s1 <= s1_nxt;
      s2 <= s2_nxt;

      out_lu_data_wr       <= s2.wr && !s2_upd_eff;
      out_lu_data          <= s2_upd_eff ? '0 : s2.data;
      out_lu_data_valid    <= s2.valid && !s2_upd_eff;
      out_lu_data_valid_wr <= s2.valid_wr && !s2_upd_eff;

      if (in_lu_data_wr && !orphan) begin
        idx <= cur_idx;
      end

      if (is_head) begin
        pkt_open <= 1'b1;
      end else if (is_tail) begin
        pkt_open <= 1'b0;
      end

      if (is_head || is_tail) begin
        cls_upd <= 1'b0;
      end else if (match) begin
        cls_upd <= 1'b1;
      end

      if (cap6) begin
        sh_mac <= in_lu_data[127:80];
        sh_dir <= in_lu_data[79];
        sh_tb  <= in_lu_data[63:32];
      end

      // A tail landing on beat 6 commits the beat's own fields directly,
      // since the shadows only capture them on this same edge.
      if (commit) begin
        direct_mac_addr      <= cap6 ? in_lu_data[127:80] : sh_mac;
        direction            <= cap6 ? in_lu_data[79]     : sh_dir;
        token_bucket_para    <= cap6 ? in_lu_data[63:32]  : sh_tb;
        beacon_update_master <= !beacon_update_master;
        update_cnt           <= update_cnt + 32'd1;
      end

      drop_cnt <= drop_cnt + 32'(orphan) + 32'(supp);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lupdate_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_lupdate_parser
// Purpose : Scoreboard bench for lupdate_parser. The driver queues every beat
//           expected at the output with its due cycle; a monitor compares
//           output beats against the queue and checks idle cycles are zero.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lupdate_parser;

  localparam logic [47:0] CNC   = 48'h010203040506;
  localparam logic [47:0] LOCAL = 48'h112233445566;
  localparam logic [47:0] OTHER = 48'h0A0B0C0D0E0F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_wr = 1'b0;
  logic [133:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_vwr = 1'b0;
  logic         out_wr;
  logic [133:0] out_data;
  logic         out_valid, out_vwr;
  logic         direction, beacon_update_master;
  logic [31:0]  token_bucket_para, update_cnt, drop_cnt;
  logic [47:0]  direct_mac_addr;

  always #5 clk = ~clk;

  lupdate_parser #(.CNC_MAC(CNC), .RST_TB_PARA(32'h0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_lu_data_wr        (in_wr),
    .in_lu_data           (in_data),
    .in_lu_data_valid     (in_valid),
    .in_lu_data_valid_wr  (in_vwr),
    .in_local_mac_id      (LOCAL),
    .out_lu_data_wr       (out_wr),
    .out_lu_data          (out_data),
    .out_lu_data_valid    (out_valid),
    .out_lu_data_valid_wr (out_vwr),
    .direction            (direction),
    .token_bucket_para    (token_bucket_para),
    .direct_mac_addr      (direct_mac_addr),
    .beacon_update_master (beacon_update_master),
    .update_cnt           (update_cnt),
    .drop_cnt             (drop_cnt)
  );

  typedef struct {
    logic [133:0] data;
    logic         valid;
    logic         vwr;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every output beat must match the head of the scoreboard at its
  // due cycle; idle cycles must show zero data and no valid strobe.
  always @(negedge clk) begin
    if (out_wr) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%h required=none", out_data);
      end else begin
        e = q.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_flags", 134'({out_valid, out_vwr}), 134'({e.valid, e.vwr}));
        chk("beat_latency", 134'(cyc), 134'(e.cyc));
      end
    end else begin
      chk("idle_out", 134'({out_vwr, out_valid}), 134'(0));
      chk("idle_data", out_data, 134'(0));
    end
  end

  function automatic logic [133:0] mk_beat(input int i, input int n, input logic has_tail,
                                           input logic [47:0] dmac, input logic [47:0] smac,
                                           input logic [7:0] seed, input logic [47:0] m6,
                                           input logic d6, input logic [31:0] t6);
    logic [127:0] p;
    logic [1:0]   tg;
    p = {16{seed ^ 8'(i)}};
    if (i == 2) begin
      p[127:80] = dmac;
      p[79:32]  = smac;
      p[31:16]  = 16'h88F7;
      p[11:8]   = 4'hD;
    end
    if (i == 6) begin
      p[127:80] = m6;
      p[79]     = d6;
      p[63:32]  = t6;
    end
    tg = (i == 0) ? 2'b01 : ((has_tail && i == n - 1) ? 2'b10 : 2'b11);
    return {tg, (has_tail && i == n - 1) ? 4'h5 : 4'h0, p};
  endfunction

  task automatic drive_beat(input logic [133:0] d, input logic tl);
    @(negedge clk);
    in_wr    = 1'b1;
    in_data  = d;
    in_valid = tl;
    in_vwr   = tl;
  endtask

  task automatic go_idle(input int k);
    @(negedge clk);
    in_wr = 1'b0; in_data = '0; in_valid = 1'b0; in_vwr = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic send_pkt(input int n, input logic [47:0] dmac, input logic [47:0] smac,
                          input logic fwd, input logic has_tail, input logic [7:0] seed,
                          input logic [47:0] m6, input logic d6, input logic [31:0] t6);
    logic [133:0] b;
    logic         tl;
    for (int i = 0; i < n; i++) begin
      b  = mk_beat(i, n, has_tail, dmac, smac, seed, m6, d6, t6);
      tl = has_tail && (i == n - 1);
      drive_beat(b, tl);
      if (fwd) q.push_back('{b, tl, tl, cyc + 3});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_wr = 1'b0; in_data = '0; in_valid = 1'b0; in_vwr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_regs(input logic [47:0] mac, input logic dir, input logic [31:0] tb,
                          input logic bum, input logic [31:0] ucnt, input logic [31:0] dcnt);
    chk("direct_mac_addr", 134'(direct_mac_addr), 134'(mac));
    chk("direction", 134'(direction), 134'(dir));
    chk("token_bucket_para", 134'(token_bucket_para), 134'(tb));
    chk("beacon_update_master", 134'(beacon_update_master), 134'(bum));
    chk("update_cnt", 134'(update_cnt), 134'(ucnt));
    chk("drop_cnt", 134'(drop_cnt), 134'(dcnt));
  endtask

  initial begin
    logic [133:0] b;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_wr", 134'(out_wr), 134'(0));
    chk_regs(48'h0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);

    // 13-beat report packet: passes through untouched
    send_pkt(13, CNC, LOCAL, 1'b1, 1'b1, 8'h10, 48'h0, 1'b0, 32'h0);
    go_idle(6);
    chk_regs(48'h0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);

    // 8-beat update: fully suppressed, committed at tail
    send_pkt(8, LOCAL, CNC, 1'b0, 1'b1, 8'h20, 48'hAABBCCDDEEFF, 1'b1, 32'h12345678);
    go_idle(6);
    chk_regs(48'hAABBCCDDEEFF, 1'b1, 32'h12345678, 1'b1, 32'd1, 32'd8);

    // same update with wrong source MAC: forwarded, registers untouched
    send_pkt(8, LOCAL, OTHER, 1'b1, 1'b1, 8'h30, 48'h998877665544, 1'b0, 32'hFFFF0000);
    go_idle(6);
    chk_regs(48'hAABBCCDDEEFF, 1'b1, 32'h12345678, 1'b1, 32'd1, 32'd8);

    // 7-beat update: tail is beat 6 itself
    send_pkt(7, LOCAL, CNC, 1'b0, 1'b1, 8'h40, 48'h665544332211, 1'b0, 32'hCAFEF00D);
    go_idle(6);
    chk_regs(48'h665544332211, 1'b0, 32'hCAFEF00D, 1'b0, 32'd2, 32'd15);

    // unterminated packet abandoned by a new head, both forwarded
    send_pkt(2, LOCAL, CNC, 1'b1, 1'b0, 8'h50, 48'h0, 1'b0, 32'h0);
    send_pkt(3, CNC, LOCAL, 1'b1, 1'b1, 8'h60, 48'h0, 1'b0, 32'h0);
    go_idle(6);
    chk_regs(48'h665544332211, 1'b0, 32'hCAFEF00D, 1'b0, 32'd2, 32'd15);

    // 5-beat update: suppressed, tail too early to commit
    do_reset();
    send_pkt(5, LOCAL, CNC, 1'b0, 1'b1, 8'h70, 48'hAABBCCDDEEFF, 1'b1, 32'h12345678);
    go_idle(6);
    chk_regs(48'h0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd5);

    // two orphan middle beats, then a 2-beat packet
    do_reset();
    b = {2'b11, 4'h0, 128'hDEADBEEF_00000000_11111111_22222222};
    drive_beat(b, 1'b0);
    b = {2'b11, 4'h0, 128'hDEADBEEF_33333333_44444444_55555555};
    drive_beat(b, 1'b0);
    send_pkt(2, LOCAL, CNC, 1'b1, 1'b1, 8'h80, 48'h0, 1'b0, 32'h0);
    go_idle(6);
    chk_regs(48'h0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd2);

    // reset for one cycle at beat 4 of an update
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b = mk_beat(i, 8, 1'b1, LOCAL, CNC, 8'h90, 48'hAABBCCDDEEFF, 1'b1, 32'h12345678);
      drive_beat(b, i == 7);
      rst = (i == 4);
      if (i == 5) begin
        chk("rst_out_wr", 134'(out_wr), 134'(0));
        chk_regs(48'h0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
      end
    end
    go_idle(6);
    chk_regs(48'h0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd3);

    chk("scoreboard_empty", 134'(q.size()), 134'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
